// File: rtl/result_screen_drawer.sv
// ============================================================================
//  Module      : result_screen_drawer
//  Description : Animated WIN/LOSE end-of-level screen on a tile grid:
//                row-by-row reveal, blinking hold, then static face.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_screen_drawer #(
    parameter int          SCREEN_WIDTH  = 640,
    parameter int          SCREEN_HEIGHT = 480,
    parameter int          BLOCK_WIDTH   = 40,
    parameter int          REVEAL_FRAMES = 4,
    parameter int          BLINK_FRAMES  = 30,
    parameter int          HOLD_FRAMES   = 180,
    parameter logic [11:0] FG_COLOR      = 12'h000,
    parameter logic [11:0] WIN_BG        = 12'h5AF,
    parameter logic [11:0] LOSE_BG       = 12'hA00
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic       show_win,
    input  logic       show_lose,
    input  int         row,
    input  int         column,
    input  logic       display_enable,
    output logic [3:0] vga_red,
    output logic [3:0] vga_green,
    output logic [3:0] vga_blue,
    output logic       active,
    output logic       screen_done
);

    localparam int c_ty         = SCREEN_HEIGHT / BLOCK_WIDTH;
    localparam int c_max_frames = (HOLD_FRAMES > REVEAL_FRAMES) ? HOLD_FRAMES : REVEAL_FRAMES;
    localparam int c_cnt_w      = $clog2(c_max_frames) + 1;
    localparam int c_rev_w      = $clog2(c_ty + 1);
    localparam int c_blink_w    = $clog2(BLINK_FRAMES) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REVEAL = 2'd1,
        S_HOLD   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_mode_lose;
    logic [c_rev_w-1:0]   r_revealed;
    logic [c_cnt_w-1:0]   r_frame_cnt;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_phase;
    logic [11:0]          r_rgb;

    logic                 w_frame_tick;
    logic                 w_start;
    int                   w_tr;
    int                   w_tc;
    logic                 w_fg;
    logic [11:0]          w_color;

    // Face bitmap: eyes shared, mouth corners/bar swap rows between modes.
    function automatic logic face_hit(input int tr, input int tc, input logic lose);
        int   corner_row;
        int   bar_row;
        logic eye;
        corner_row = lose ? 8 : 7;
        bar_row    = lose ? 7 : 8;
        eye        = (tr == 3 || tr == 4) && (tc == 5 || tc == 10);
        return eye
            || (tr == corner_row && (tc == 3 || tc == 12))
            || (tr == bar_row && tc >= 4 && tc <= 11);
    endfunction

    assign w_frame_tick = display_enable
                       && (row == SCREEN_HEIGHT - 1)
                       && (column == SCREEN_WIDTH - 1);
    assign w_start      = show_win | show_lose;

    assign w_tr = row / BLOCK_WIDTH;
    assign w_tc = column / BLOCK_WIDTH;

    assign w_fg = face_hit(w_tr, w_tc, r_mode_lose)
               && (w_tr < int'(r_revealed))
               && !(r_state == S_HOLD && r_blink_phase);

    always_comb begin
        w_color = 12'h000;
        if (r_state != S_IDLE && display_enable) begin
            if (w_fg) begin
                w_color = FG_COLOR;
            end else begin
                w_color = r_mode_lose ? LOSE_BG : WIN_BG;
            end
        end
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_mode_lose   <= 1'b0;
            r_revealed    <= '0;
            r_frame_cnt   <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state       <= S_REVEAL;
                        r_mode_lose   <= ~show_win;
                        r_revealed    <= '0;
                        r_frame_cnt   <= '0;
                        r_blink_cnt   <= '0;
                        r_blink_phase <= 1'b0;
                    end
                end
                S_REVEAL: begin
                    if (w_frame_tick) begin
                        if (r_frame_cnt == c_cnt_w'(REVEAL_FRAMES - 1)) begin
                            r_frame_cnt <= '0;
                            r_revealed  <= r_revealed + 1'b1;
                            if (r_revealed == c_rev_w'(c_ty - 1)) begin
                                r_state       <= S_HOLD;
                                r_blink_cnt   <= '0;
                                r_blink_phase <= 1'b0;
                            end
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_frame_tick) begin
                        if (r_frame_cnt == c_cnt_w'(HOLD_FRAMES - 1)) begin
                            r_state       <= S_DONE;
                            r_frame_cnt   <= '0;
                            r_blink_cnt   <= '0;
                            r_blink_phase <= 1'b0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                            // Separate blink counter avoids a non-power-of-two modulo.
                            if (r_blink_cnt == c_blink_w'(BLINK_FRAMES - 1)) begin
                                r_blink_cnt   <= '0;
                                r_blink_phase <= ~r_blink_phase;
                            end else begin
                                r_blink_cnt <= r_blink_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            r_rgb <= 12'h000;
        end else begin
            r_rgb <= w_color;
        end
    end

    assign vga_red     = r_rgb[11:8];
    assign vga_green   = r_rgb[7:4];
    assign vga_blue    = r_rgb[3:0];
    assign active      = (r_state != S_IDLE);
    assign screen_done = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: doc/result_screen_drawer.md
Name: result_screen_drawer

Overview:
Parametrised successor to the static win-screen drawer. Renders an animated end-of-level screen, either WIN (smiling face) or LOSE (frowning face), on a tile grid. The face is revealed row by row, blinks for a hold period, then stays static. Sits beside the game-play drawer; the top level muxes its RGB onto the VGA pins when `active`=1.

Parameters:
- SCREEN_WIDTH, 640, visible columns.
- SCREEN_HEIGHT, 480, visible rows.
- BLOCK_WIDTH, 40, tile edge in pixels. Grid is TX=SCREEN_WIDTH/BLOCK_WIDTH (16) by TY=SCREEN_HEIGHT/BLOCK_WIDTH (12).
- REVEAL_FRAMES, 4, frames per revealed tile row.
- BLINK_FRAMES, 30, frames per blink half-period.
- HOLD_FRAMES, 180, frames spent blinking.
- FG_COLOR, 12'h000, face colour {R,G,B}.
- WIN_BG, 12'h5AF, win background.
- LOSE_BG, 12'hA00, lose background.

Ports:
- vga_clock  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- show_win  in  1  start-win request (level sampled).
- show_lose  in  1  start-lose request (level sampled).
- row  in  int  current pixel row.
- column  in  int  current pixel column.
- display_enable  in  1  visible-area flag.
- vga_red  out  4  red.
- vga_green  out  4  green.
- vga_blue  out  4  blue.
- active  out  1  1 whenever state is not IDLE.
- screen_done  out  1  1 while in DONE.

Behaviour:
- **Reset** (reset=0, async): state=IDLE, mode=WIN, revealed=0, frame_cnt=0, blink_phase=0. All outputs 0.
- **frame_tick**: 1 in the single cycle where display_enable=1, row=SCREEN_HEIGHT-1 and column=SCREEN_WIDTH-1.
- **Tile coordinates**: tr=row/BLOCK_WIDTH, tc=column/BLOCK_WIDTH. Integer divide, parameter-constant.
- **Pattern, both modes**: eyes at (tr 3..4, tc 5) and (tr 3..4, tc 10).
- **Pattern, WIN mouth**: (tr 7, tc 3), (tr 7, tc 12), and (tr 8, tc 4..11).
- **Pattern, LOSE mouth**: (tr 8, tc 3), (tr 8, tc 12), and (tr 7, tc 4..11).
- **pix_fg** = pattern hit AND tr<revealed AND NOT (state=HOLD AND blink_phase=1).
- **Colour**: FG_COLOR if pix_fg, else the mode background. Black if state=IDLE or display_enable=0.
- **Latency**: RGB is registered. Output reflects the row/column/display_enable of the previous cycle (1-cycle latency).
- **FSM states**: IDLE, REVEAL, HOLD, DONE.
  - IDLE→REVEAL on show_win|show_lose. Latch mode (win has priority if both are 1). revealed=0, frame_cnt=0.
  - REVEAL: on each frame_tick, frame_cnt++. When frame_cnt reaches REVEAL_FRAMES-1 on a tick: frame_cnt=0 and revealed++. When revealed becomes TY: go to HOLD with frame_cnt=0, blink_phase=0.
  - HOLD: on each frame_tick, frame_cnt++. blink_phase toggles on every tick where (frame_cnt+1) mod BLINK_FRAMES = 0. On the tick where frame_cnt+1=HOLD_FRAMES: go to DONE, blink_phase=0.
  - DONE: full face, static. Start requests are accepted again here: show_win|show_lose restarts REVEAL with the new mode.
- **Ignored requests**: show_win/show_lose in REVEAL or HOLD are ignored (no restart, no mode change).
- **Counter widths**: sized by $clog2 of the larger of HOLD_FRAMES and REVEAL_FRAMES, plus 1. revealed is $clog2(TY+1) bits. No wrap is possible.
- **Reset mid-animation**: returns immediately to IDLE; RGB is black the next cycle.

Test Plan:
1. Reset low then high, show_win pulse. After 4 frame_ticks, revealed=1. Row 0 shows WIN_BG 5/A/F; rows ≥40 are black? No: rows ≥40 show WIN_BG with no face. Pixel (row 120, col 200) shows WIN_BG, because tile row 3 is not yet revealed.
2. Complete reveal (48 ticks) → active=1, state HOLD. Pixel (row 130, col 210) = FG 0/0/0. After 30 more ticks the same pixel shows WIN_BG (blink). After 30 more it shows FG again.
3. 180 HOLD ticks → screen_done=1, pixel steady FG. Then show_lose → REVEAL in LOSE mode. Pixel (row 300, col 180), tile (7,4), is FG after full reveal; the same pixel is BG in WIN mode.
4. show_win and show_lose asserted together in IDLE → WIN mode. show_lose during HOLD → no state or mode change.
5. display_enable=0 while in HOLD → RGB=0 one cycle later. RGB changes exactly 1 cycle after a row/column transition across a tile edge.
6. Assert reset mid-REVEAL (revealed=5) → outputs 0 immediately; active=0; a later show_win restarts with revealed=0.
